exhaustive_vector_checker: RTL and testbench
============================================

// Module: exhaustive_vector_checker
// PURPOSE
//  Self-checking stimulus/response stage that wraps a small combinational DUT (e.g. andgate) in
//  hardware. Walks every input vector 0..2^IN_W-1 into the DUT, waits a settle window, samples the
//  DUT output and compares it against a golden-model output. Reports mismatch count, first failing
//  vector and a final pass flag, so evolved (CGP) and reference netlists are checked in one run.
// PARAMETERS
//  IN_W     2   DUT input width; vec_o bit 0 = DUT input a, bit 1 = b, ...
//  OUT_W    1   DUT / golden output width
//  SETTLE   1   extra cycles each vector is held before sampling (must be >= 1)
//  ERR_W    16  width of the mismatch counter
// PORTS
//  clk              in   1      clock, rising edge
//  rst_n            in   1      asynchronous active-low reset
//  start            in   1      1-cycle pulse; begins a run from IDLE or DONE
//  vec_o            out  IN_W   registered vector driven to DUT inputs
//  dut_y_i          in   OUT_W  DUT output
//  gold_y_i         in   OUT_W  golden-model output for the same vec_o
//  busy             out  1      high from run start until the last compare is registered
//  done             out  1      high in DONE, held until next start or reset
//  pass             out  1      valid while done: 1 iff err_cnt == 0
//  err_cnt          out  ERR_W  mismatch count, saturates at all-ones
//  first_err_vec    out  IN_W   vec_o of the first mismatch of the run
//  first_err_valid  out  1      1 once first_err_vec has been captured in this run
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0 (vec_o, busy, done, pass, err_cnt,
//    first_err_vec, first_err_valid). Reset mid-run aborts immediately; no partial results kept.
//  - States: IDLE -> (start) APPLY -> SAMPLE -> APPLY (next vector) ... -> DONE -> (start) APPLY.
//  - start edge in IDLE/DONE: next cycle vec_o=0, busy=1, done=0, pass=0, err_cnt=0,
//    first_err_valid=0, settle counter loaded with SETTLE.
//  - APPLY: vec_o held; settle counter decrements each cycle; when it reaches 0 go to SAMPLE.
//  - SAMPLE (1 cycle): compare dut_y_i vs gold_y_i (case inequality: X/Z on dut_y_i counts as a
//    mismatch in simulation). On mismatch: err_cnt+1 (no wrap past all-ones); if
//    first_err_valid=0, capture first_err_vec=vec_o and set first_err_valid=1.
//  - Each vector is therefore held exactly SETTLE+1 cycles. After SAMPLE of the all-ones vector
//    go to DONE; otherwise vec_o increments, counter reloads, back to APPLY.
//  - Vector counter is IN_W+1 bits internally; end detected on vec_o == 2^IN_W-1 in SAMPLE, so
//    vec_o never wraps to 0 during a run; vec_o holds the last vector in DONE.
//  - Run latency: start seen at edge 0 -> done=1 after 1 + 2^IN_W*(SETTLE+1) edges.
//  - DONE: busy=0, done=1, pass=(err_cnt==0); results stable until start or reset.
//  - start while busy is ignored (no restart, no effect on counters).
//  - start coincident with the final SAMPLE is ignored; a new start is needed in DONE.
// TESTING (IN_W=2, OUT_W=1, SETTLE=1 unless noted; DUT = andgate)
//  1 gold=a&b, start pulse -> vec_o 0,0,1,1,2,2,3,3; done=1 9 edges after start; pass=1, err_cnt=0,
//    first_err_valid=0.
//  2 gold=a|b -> err_cnt=2, pass=0, first_err_vec=2'b01, first_err_valid=1.
//  3 ERR_W=1, gold=~(a&b) -> 4 mismatches, err_cnt saturates at 1, pass=0, first_err_vec=0.
//  4 rst_n=0 asynchronously while vec_o=2 (mid-run) -> all outputs 0 immediately, state IDLE;
//    a new start gives a clean run identical to scenario 1.
//  5 start pulsed again while busy -> ignored, same timing as 1; start from DONE after scenario 2
//    with gold fixed -> counters cleared, pass=1.
//  6 DUT output forced to X for vec 3 -> counted as mismatch: err_cnt=1, first_err_vec=3.

Source files
------------

// File: rtl/exhaustive_vector_checker_if.sv
// Stimulus/response bundle between the vector checker, the DUT under test and its golden model.
// The master side is the checker; the slave side is the surrounding DUT/golden/control logic.
interface exhaustive_vector_checker_if #(
   parameter int IN_W  = 2,
   parameter int OUT_W = 1,
   parameter int ERR_W = 16
);
   logic             start;
   logic [IN_W-1:0]  vec_o;
   logic [OUT_W-1:0] dut_y_i;
   logic [OUT_W-1:0] gold_y_i;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [IN_W-1:0]  first_err_vec;
   logic             first_err_valid;

   modport master (
      input  start, dut_y_i, gold_y_i,
      output vec_o, busy, done, pass, err_cnt, first_err_vec, first_err_valid
   );

   modport slave (
      output start, dut_y_i, gold_y_i,
      input  vec_o, busy, done, pass, err_cnt, first_err_vec, first_err_valid
   );
endinterface

// File: rtl/exhaustive_vector_checker.sv
// Walks every input vector into a combinational DUT, holds each for SETTLE+1 cycles and compares
// the DUT output against a golden model, reporting mismatch count, first failing vector and pass.
//
// state    | meaning
// S_IDLE   | out of reset, waiting for start
// S_APPLY  | vector driven, settle timer counting down
// S_SAMPLE | one-cycle compare of dut_y_i vs gold_y_i
// S_DONE   | run finished, results held until start or reset
module exhaustive_vector_checker #(
   parameter int IN_W   = 2,
   parameter int OUT_W  = 1,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   exhaustive_vector_checker_if.master bus
);
   localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [IN_W:0]    VEC_ONE   = (IN_W + 1)'(1);
   localparam logic [IN_W:0]    LAST_VEC  = {1'b0, {IN_W{1'b1}}};
   localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

   state_t           state, state_nx;
   logic [IN_W:0]    vec_cnt;
   logic [CNT_W-1:0] settle_cnt;
   logic [ERR_W-1:0] err_cnt;
   logic [IN_W-1:0]  first_err_vec;
   logic             first_err_valid;
   logic             launch;
   logic             settle_tc;
   logic             last_vec;
   logic             mismatch;

   assign settle_tc = (settle_cnt == CNT_ONE);
   assign last_vec  = (vec_cnt == LAST_VEC);
   // Case inequality so an X/Z from the DUT is reported as a failure in simulation.
   assign mismatch  = (bus.dut_y_i !== bus.gold_y_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_nx = S_APPLY;
               launch   = 1'b1;
            end
         end
         S_APPLY:  if (settle_tc) state_nx = S_SAMPLE;
         S_SAMPLE: state_nx = last_vec ? S_DONE : S_APPLY;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt         <= '0;
         settle_cnt      <= '0;
         err_cnt         <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
      end else if (launch) begin
         vec_cnt         <= '0;
         settle_cnt      <= SETTLE_LD;
         err_cnt         <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
      end else begin
         case (state)
            S_APPLY: settle_cnt <= settle_cnt - CNT_ONE;
            S_SAMPLE: begin
               if (mismatch) begin
                  if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
                  if (!first_err_valid) begin
                     first_err_vec   <= vec_cnt[IN_W-1:0];
                     first_err_valid <= 1'b1;
                  end
               end
               // Last vector is held into DONE rather than wrapping back to 0.
               if (!last_vec) begin
                  vec_cnt    <= vec_cnt + VEC_ONE;
                  settle_cnt <= SETTLE_LD;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.vec_o           = vec_cnt[IN_W-1:0];
   assign bus.busy            = (state == S_APPLY) || (state == S_SAMPLE);
   assign bus.done            = (state == S_DONE);
   assign bus.pass            = (state == S_DONE) && (err_cnt == '0);
   assign bus.err_cnt         = err_cnt;
   assign bus.first_err_vec   = first_err_vec;
   assign bus.first_err_valid = first_err_valid;
endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Directed bench for exhaustive_vector_checker wrapping an AND gate against selectable golden models.
module tb_exhaustive_vector_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   exhaustive_vector_checker_if #(.IN_W(2), .OUT_W(1), .ERR_W(16)) bus ();
   exhaustive_vector_checker_if #(.IN_W(2), .OUT_W(1), .ERR_W(1))  bus1 ();

   exhaustive_vector_checker #(.IN_W(2), .OUT_W(1), .SETTLE(1), .ERR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   exhaustive_vector_checker #(.IN_W(2), .OUT_W(1), .SETTLE(1), .ERR_W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));

   int   gold_mode = 0;   // 0: a&b, 1: a|b, 2: ~(a&b)
   logic force_x = 1'b0;

   assign bus.dut_y_i  = (force_x && bus.vec_o == 2'd3) ? 1'bx : (bus.vec_o[0] & bus.vec_o[1]);
   assign bus.gold_y_i = (gold_mode == 0) ? (bus.vec_o[0] & bus.vec_o[1]) :
                         (gold_mode == 1) ? (bus.vec_o[0] | bus.vec_o[1]) :
                                            ~(bus.vec_o[0] & bus.vec_o[1]);
   assign bus1.dut_y_i  = bus1.vec_o[0] & bus1.vec_o[1];
   assign bus1.gold_y_i = ~(bus1.vec_o[0] & bus1.vec_o[1]);

   typedef struct {
      int err;
      int fev;
      int fvalid;
      int pass;
   } exp_t;

   exp_t sb_q[$];
   int   vec_q[$];
   int   n_assert = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int mode, input bit fx, input int err_max);
      exp_t e;
      e = '{err: 0, fev: 0, fvalid: 0, pass: 0};
      for (int v = 0; v < 4; v++) begin
         bit a, b, d, g, mis;
         a = v[0];
         b = v[1];
         d = a & b;
         g = (mode == 0) ? (a & b) : (mode == 1) ? (a | b) : ~(a & b);
         mis = (fx && v == 3) ? 1'b1 : (d != g);
         if (mis) begin
            if (e.fvalid == 0) begin
               e.fev    = v;
               e.fvalid = 1;
            end
            if (e.err < err_max) e.err++;
         end
      end
      e.pass = (e.err == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic run(input int mode, input bit fx, input int restart_at, input string tag);
      int   edges;
      int   exp_v;
      exp_t e;
      gold_mode = mode;
      force_x   = fx;
      sb_q.push_back(model(mode, fx, 65535));
      for (int v = 0; v < 4; v++) begin
         vec_q.push_back(v);
         vec_q.push_back(v);
      end
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      edges = 1;
      while (bus.busy && edges < 40) begin
         exp_v = (vec_q.size() > 0) ? vec_q.pop_front() : -1;
         check({tag, "_vec"}, 32'(bus.vec_o), exp_v);
         if (edges == restart_at) bus.start = 1'b1;
         @(posedge clk);
         #1 bus.start = 1'b0;
         edges++;
      end
      check({tag, "_latency"}, edges, 9);
      check({tag, "_done"}, 32'(bus.done), 1);
      check({tag, "_busy_low"}, 32'(bus.busy), 0);
      check({tag, "_vec_left"}, vec_q.size(), 0);
      vec_q.delete();
      e = sb_q.pop_front();
      check({tag, "_err_cnt"}, 32'(bus.err_cnt), e.err);
      check({tag, "_pass"}, 32'(bus.pass), e.pass);
      check({tag, "_first_err_valid"}, 32'(bus.first_err_valid), e.fvalid);
      check({tag, "_first_err_vec"}, 32'(bus.first_err_vec), e.fev);
   endtask

   initial begin
      int   k;
      exp_t e1;
      bus.start  = 1'b0;
      bus1.start = 1'b0;
      #2;
      check("rst_vec", 32'(bus.vec_o), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_pass", 32'(bus.pass), 0);
      check("rst_err_cnt", 32'(bus.err_cnt), 0);
      check("rst_first_err_valid", 32'(bus.first_err_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run(0, 1'b0, -1, "and_pass");
      run(1, 1'b0, -1, "or_fail");
      run(0, 1'b0, -1, "restart_fixed");
      run(0, 1'b0, 3, "start_busy");
      run(0, 1'b0, 8, "start_last");
      repeat (3) @(posedge clk);
      #1;
      check("start_last_hold_done", 32'(bus.done), 1);
      check("start_last_hold_busy", 32'(bus.busy), 0);
      check("start_last_hold_vec", 32'(bus.vec_o), 3);

      // Asynchronous reset in the middle of a run.
      gold_mode = 1;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      k = 0;
      while (bus.vec_o != 2'd2 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("midrun_reach_vec2", 32'(bus.vec_o), 2);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_rst_vec", 32'(bus.vec_o), 0);
      check("midrun_rst_busy", 32'(bus.busy), 0);
      check("midrun_rst_done", 32'(bus.done), 0);
      check("midrun_rst_err_cnt", 32'(bus.err_cnt), 0);
      check("midrun_rst_first_err_valid", 32'(bus.first_err_valid), 0);
      check("midrun_rst_first_err_vec", 32'(bus.first_err_vec), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 1'b0, -1, "after_rst");

      run(0, 1'b1, -1, "x_out");

      // Narrow error counter must saturate instead of wrapping.
      e1 = model(2, 1'b0, 1);
      @(negedge clk);
      bus1.start = 1'b1;
      @(posedge clk);
      #1 bus1.start = 1'b0;
      k = 1;
      while (!bus1.done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("sat_latency", k, 9);
      check("sat_err_cnt", 32'(bus1.err_cnt), e1.err);
      check("sat_pass", 32'(bus1.pass), e1.pass);
      check("sat_first_err_vec", 32'(bus1.first_err_vec), e1.fev);
      check("sat_first_err_valid", 32'(bus1.first_err_valid), e1.fvalid);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
